layer2_pool_window: RTL and testbench

Upstream feeder for the layer-2 max-pool stage: consumes the raster-order pixel stream from the layer-2 convolution (one pixel per accepted beat, all channels in parallel) and assembles non-overlapping 2x2 windows per channel. For each complete window it drives one wide word and a one-cycle `start` pulse directly into the pool stage's `data_in` / `start`. It owns the single line buffer needed for 2x2 stride-2 pooling and the frame row/column bookkeeping.

---
 rtl/layer2_pool_window.sv | 135 +++++++++++++
 tb/tb_layer2_pool_window.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/layer2_pool_window.sv
// Assembles non-overlapping 2x2 windows from a raster pixel stream for the layer-2 max-pool stage.
// One line buffer holds each even row; odd rows pair with it to emit one window per odd column.
module layer2_pool_window #(
    parameter int unsigned bits        = 16,
    parameter int unsigned bits_shift  = 4,
    parameter int unsigned channel_num = 8,
    parameter int unsigned img_width   = 10,
    parameter int unsigned img_height  = 10,
    parameter int unsigned col_bits    = 4
) (
    input  logic                                      clk_in,
    input  logic                                      rst_n,
    input  logic [(channel_num << bits_shift)-1:0]     data_in,
    input  logic                                      valid_in,
    output logic [((channel_num*4) << bits_shift)-1:0] data_out,
    output logic                                      start,
    output logic                                      frame_done
);

    localparam int unsigned PIX_W = channel_num << bits_shift;
    localparam int unsigned WIN_W = (channel_num * 4) << bits_shift;
    localparam int unsigned IDX_W = (img_width > 1) ? $clog2(img_width) : 1;

    localparam logic [col_bits-1:0] LAST_COL     = col_bits'(img_width - 1);
    localparam logic [col_bits-1:0] LAST_ROW     = col_bits'(img_height - 1);
    localparam logic [col_bits-1:0] LAST_ODD_COL = col_bits'((img_width / 2) * 2 - 1);
    localparam logic [col_bits-1:0] LAST_ODD_ROW = col_bits'((img_height / 2) * 2 - 1);

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [col_bits-1:0] col_q, col_d;
    logic [col_bits-1:0] row_q, row_d;
    logic [PIX_W-1:0]    left_q, left_d;
    logic [WIN_W-1:0]    data_out_q, data_out_d;
    logic                start_q, start_d;
    logic                frame_done_q, frame_done_d;

    logic [PIX_W-1:0]    line_buf_q [img_width];
    logic [PIX_W-1:0]    top_left_c, top_right_c;
    logic [WIN_W-1:0]    win_c;
    logic                col_end_c;

    // State, counters and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            left_q       <= '0;
            data_out_q   <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            left_q       <= left_d;
            data_out_q   <= data_out_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer: contents are only read after a FILL row rewrote them, so no reset
    always_ff @(posedge clk_in) begin
        if (valid_in && (state_q == FILL)) begin
            line_buf_q[IDX_W'(col_q)] <= data_in;
        end
    end

    // Window word: per channel slots TL, TR, BL, BR from low to high
    always_comb begin
        win_c       = '0;
        top_left_c  = line_buf_q[IDX_W'({col_q[col_bits-1:1], 1'b0})];
        top_right_c = line_buf_q[IDX_W'(col_q)];
        for (int c = 0; c < int'(channel_num); c++) begin
            win_c[((c*4 + 0) << bits_shift) +: bits] = top_left_c[(c << bits_shift) +: bits];
            win_c[((c*4 + 1) << bits_shift) +: bits] = top_right_c[(c << bits_shift) +: bits];
            win_c[((c*4 + 2) << bits_shift) +: bits] = left_q[(c << bits_shift) +: bits];
            win_c[((c*4 + 3) << bits_shift) +: bits] = data_in[(c << bits_shift) +: bits];
        end
    end

    // Next-state, counter advance and output decode
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        left_d       = left_q;
        data_out_d   = data_out_q;
        start_d      = 1'b0;
        frame_done_d = 1'b0;
        col_end_c    = (col_q == LAST_COL);

        if (valid_in) begin
            if (col_end_c) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + col_bits'(1);
            end else begin
                col_d = col_q + col_bits'(1);
            end

            unique case (state_q)
                FILL: begin
                    // A trailing even row of an odd-height frame stays in FILL
                    if (col_end_c && (row_q != LAST_ROW)) begin
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (!col_q[0]) begin
                        left_d = data_in;
                    end else begin
                        data_out_d   = win_c;
                        start_d      = 1'b1;
                        frame_done_d = (row_q == LAST_ODD_ROW) && (col_q == LAST_ODD_COL);
                    end
                    if (col_end_c) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign start      = start_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_layer2_pool_window.sv
// Directed scoreboard bench for layer2_pool_window: 4x4 and 5x5 instances, gaps, back-to-back frames, mid-frame reset.
module tb_layer2_pool_window;

    typedef struct {
        logic [511:0] win;
        logic         fd;
    } exp_t;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic [127:0] data_a, data_b;
    logic         valid_a, valid_b;
    logic [511:0] dout_a, dout_b;
    logic         start_a, start_b, fd_a, fd_b;

    int           checks = 0;
    int           errors = 0;
    int           fd_seen = 0;
    exp_t         sb[$];
    logic [511:0] hist[$];
    logic [511:0] ref1[$];
    logic [127:0] frm [0:9][0:9];

    always #5 clk_in = ~clk_in;

    layer2_pool_window #(
        .bits(16), .bits_shift(4), .channel_num(8),
        .img_width(4), .img_height(4), .col_bits(4)
    ) u_dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(data_a), .valid_in(valid_a),
        .data_out(dout_a), .start(start_a), .frame_done(fd_a)
    );

    layer2_pool_window #(
        .bits(16), .bits_shift(4), .channel_num(8),
        .img_width(5), .img_height(5), .col_bits(4)
    ) u_dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(data_b), .valid_in(valid_b),
        .data_out(dout_b), .start(start_b), .frame_done(fd_b)
    );

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame content: ramp 16*c + row*w + col, or random with ch7 alternating 0x8000/0xFFFF
    task automatic build(input int w, input int h, input bit neg);
        logic [15:0] v;
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++)
                for (int c = 0; c < 8; c++) begin
                    if (!neg) v = 16'(16*c + r*w + k);
                    else if (c == 7) v = ((r + k) % 2 == 1) ? 16'hFFFF : 16'h8000;
                    else v = 16'($urandom);
                    frm[r][k][c*16 +: 16] = v;
                end
    endtask

    task automatic step(input bit sel, input bit v, input int r, input int k, input int w, input int h);
        exp_t         e;
        exp_t         got;
        bit           exp_st;
        logic [511:0] ow;
        logic         os, ofd;
        @(negedge clk_in);
        valid_a = v && !sel;
        valid_b = v && sel;
        data_a  = (v && !sel) ? frm[r][k] : {4{$urandom}};
        data_b  = (v && sel)  ? frm[r][k] : {4{$urandom}};
        exp_st  = v && (r % 2 == 1) && (k % 2 == 1) && (k <= (w/2)*2 - 1) && (r <= (h/2)*2 - 1);
        if (exp_st) begin
            e.win = '0;
            for (int c = 0; c < 8; c++) begin
                e.win[(c*4 + 0)*16 +: 16] = frm[r-1][k-1][c*16 +: 16];
                e.win[(c*4 + 1)*16 +: 16] = frm[r-1][k][c*16 +: 16];
                e.win[(c*4 + 2)*16 +: 16] = frm[r][k-1][c*16 +: 16];
                e.win[(c*4 + 3)*16 +: 16] = frm[r][k][c*16 +: 16];
            end
            e.fd = (r == (h/2)*2 - 1) && (k == (w/2)*2 - 1);
            sb.push_back(e);
        end
        @(posedge clk_in);
        #1;
        os  = sel ? start_b : start_a;
        ow  = sel ? dout_b : dout_a;
        ofd = sel ? fd_b : fd_a;
        if (ofd) fd_seen++;
        check("start", 512'(os), 512'(exp_st));
        if (os) begin
            check("sb_has_entry", 512'(sb.size() != 0), 512'(1));
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("window", ow, got.win);
                check("frame_done", 512'(ofd), 512'(got.fd));
            end
            hist.push_back(ow);
        end else begin
            check("frame_done_idle", 512'(ofd), 512'(0));
        end
    endtask

    task automatic drive_frame(input bit sel, input int w, input int h, input bit gaps);
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++) begin
                step(sel, 1'b1, r, k, w, h);
                if (gaps) step(sel, 1'b0, r, k, w, h);
            end
    endtask

    task automatic compare_ref(input string tag);
        check({tag, "_count"}, 512'(hist.size()), 512'(ref1.size()));
        for (int i = 0; i < hist.size() && i < ref1.size(); i++)
            check(tag, hist[i], ref1[i]);
    endtask

    initial begin
        logic [511:0] w0;
        rst_n   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        repeat (3) @(negedge clk_in);
        check("rst_data_out", dout_a, '0);
        check("rst_start", 512'(start_a), 512'(0));
        check("rst_frame_done", 512'(fd_a), 512'(0));
        rst_n = 1'b1;

        // 4x4 ramp, continuous valid
        build(4, 4, 1'b0);
        hist.delete();
        fd_seen = 0;
        drive_frame(1'b0, 4, 4, 1'b0);
        check("s1_starts", 512'(hist.size()), 512'(4));
        check("s1_fd_count", 512'(fd_seen), 512'(1));
        if (hist.size() == 4) begin
            w0 = hist[0];
            check("s1_w0_ch0", 512'(w0[63:0]), 512'({16'd5, 16'd4, 16'd1, 16'd0}));
            check("s1_w0_ch1_s3", 512'(w0[127:112]), 512'(16'd21));
            w0 = hist[3];
            check("s1_w3_ch0", 512'(w0[63:0]), 512'({16'd15, 16'd14, 16'd11, 16'd10}));
        end
        ref1 = hist;

        // Same frame with valid toggling
        hist.delete();
        drive_frame(1'b0, 4, 4, 1'b1);
        compare_ref("s2_window");

        // 5x5 ramp, two frames back-to-back
        build(5, 5, 1'b0);
        hist.delete();
        fd_seen = 0;
        drive_frame(1'b1, 5, 5, 1'b0);
        drive_frame(1'b1, 5, 5, 1'b0);
        check("s3_starts", 512'(hist.size()), 512'(8));
        check("s3_fd_count", 512'(fd_seen), 512'(2));

        // Negative values in ch7
        build(4, 4, 1'b1);
        hist.delete();
        drive_frame(1'b0, 4, 4, 1'b0);
        check("s4_starts", 512'(hist.size()), 512'(4));
        if (hist.size() != 0) begin
            w0 = hist[0];
            check("s4_ch7", 512'(w0[511:448]), 512'({16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000}));
        end

        // Mid-frame reset after 6 beats, then full restart
        build(4, 4, 1'b0);
        hist.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i / 4, i % 4, 4, 4);
        check("s5_pre_rst_start", 512'(start_a), 512'(1));
        rst_n   = 1'b0;
        valid_a = 1'b0;
        #2;
        check("s5_rst_data_out", dout_a, '0);
        check("s5_rst_start", 512'(start_a), 512'(0));
        check("s5_rst_fd", 512'(fd_a), 512'(0));
        @(negedge clk_in);
        rst_n = 1'b1;
        hist.delete();
        drive_frame(1'b0, 4, 4, 1'b0);
        compare_ref("s5_window");

        step(1'b0, 1'b0, 0, 0, 4, 4);
        check("sb_drained", 512'(sb.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
